// File: rtl/slim_behavior_ctrl_pkg.sv
// Shared definitions for the slime enemy controller and its sprite renderer.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package slim_behavior_ctrl_pkg;

    // Controller state encoding. The renderer decodes the same values.
    typedef enum logic [1:0] {
        ST_WALK   = 2'd0,
        ST_FROZEN = 2'd1,
        ST_DEAD   = 2'd2
    } slim_state_t;

    // Sprite geometry, in pixels.
    localparam int unsigned SPRITE_W = 34;
    localparam int unsigned SCREEN_W = 640;

    // Default behaviour parameters.
    localparam int unsigned X_INIT_DEF       = 240;
    localparam int unsigned Y_INIT_DEF       = 192;
    localparam int unsigned PATROL_STEPS_DEF = 64;
    localparam int unsigned FREEZE_TICKS_DEF = 127;
    localparam int unsigned WALK_PERIOD_DEF  = 9;
    localparam int unsigned X_MIN_DEF        = 0;
    localparam int unsigned X_MAX_DEF        = SCREEN_W - SPRITE_W;

    // Frame-select thresholds. A counter below TH_MID selects frame 0,
    // from TH_MID up to TH_HI-1 frame 1, and TH_HI or above frame 2.
    localparam int unsigned WALK_TH_MID = 2;
    localparam int unsigned WALK_TH_HI  = 6;
    localparam int unsigned FZ_TH_MID   = 2;
    localparam int unsigned FZ_TH_HI    = 8;

    // A second hit only shatters once the freeze has aged this many ticks;
    // earlier hits are the same collision still overlapping the sprite.
    localparam int unsigned FZ_HIT_MIN = 2;

    // Freeze counter width; FREEZE_TICKS must stay below 2**FZ_W.
    localparam int unsigned FZ_W = 7;

    // Three-way bucketing of a counter into a frame index.
    function automatic logic [1:0] frame_bucket(input int unsigned v,
                                                input int unsigned th_mid,
                                                input int unsigned th_hi);
        logic [1:0] sel;
        sel = 2'd0;
        if (v >= th_hi) begin
            sel = 2'd2;
        end else if (v >= th_mid) begin
            sel = 2'd1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/slim_behavior_ctrl_frame_map.sv
// Maps walk/freeze counters onto sprite ROM frame indices.
// Latency: purely combinational; the parent registers the results.
// Backpressure: none.
//
// Ports:
//   anim_cnt  in   AW    walk animation counter
//   fz_cnt    in   FZ_W  freeze counter
//   anim_sel  out  2     walk frame 0/1/2
//   fz_stage  out  2     freeze frame 0/1/2
module slim_behavior_ctrl_frame_map
    import slim_behavior_ctrl_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic [AW-1:0]   anim_cnt,
    input  logic [FZ_W-1:0] fz_cnt,
    output logic [1:0]      anim_sel,
    output logic [1:0]      fz_stage
);

    assign anim_sel = frame_bucket(32'(anim_cnt), WALK_TH_MID, WALK_TH_HI);
    assign fz_stage = frame_bucket(32'(fz_cnt), FZ_TH_MID, FZ_TH_HI);

endmodule

// File: rtl/slim_behavior_ctrl.sv
// Sequences one slime enemy: patrol, freeze on ice hit, thaw, shatter, respawn.
// Latency: every output is registered; a tick/hit/respawn pulse shows 1 cycle later.
// Backpressure: none; single-cycle pulses are consumed on the cycle they arrive.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   tick       1-cycle game-step pulse
//   hit        1-cycle ice-projectile hit pulse
//   respawn    1-cycle respawn request, acted on only while dead
//   x_slim     sprite left x (10b);  y_slim sprite top y (9b, constant)
//   dir        0=left 1=right (renderer mirrors when 1)
//   anim_sel   walk frame 0/1/2;  fz_stage freeze frame 0/1/2
//   frozen     high while frozen;  alive low once shattered
module slim_behavior_ctrl
    import slim_behavior_ctrl_pkg::*;
#(
    parameter int X_INIT       = X_INIT_DEF,
    parameter int Y_INIT       = Y_INIT_DEF,
    parameter int PATROL_STEPS = PATROL_STEPS_DEF,
    parameter int FREEZE_TICKS = FREEZE_TICKS_DEF,
    parameter int WALK_PERIOD  = WALK_PERIOD_DEF,
    parameter int X_MIN        = X_MIN_DEF,
    parameter int X_MAX        = X_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       hit,
    input  logic       respawn,
    output logic [9:0] x_slim,
    output logic [8:0] y_slim,
    output logic       dir,
    output logic [1:0] anim_sel,
    output logic [1:0] fz_stage,
    output logic       frozen,
    output logic       alive
);

    localparam int SW = (PATROL_STEPS > 1) ? $clog2(PATROL_STEPS) : 1;
    localparam int AW = (WALK_PERIOD  > 1) ? $clog2(WALK_PERIOD)  : 1;

    localparam logic [9:0]      X_INIT_V  = 10'(X_INIT);
    localparam logic [9:0]      X_MIN_V   = 10'(X_MIN);
    localparam logic [9:0]      X_MAX_V   = 10'(X_MAX);
    localparam logic [8:0]      Y_INIT_V  = 9'(Y_INIT);
    localparam logic [SW-1:0]   STEP_LAST = SW'(PATROL_STEPS - 1);
    localparam logic [AW-1:0]   ANIM_LAST = AW'(WALK_PERIOD - 1);
    localparam logic [FZ_W-1:0] FZ_LAST   = FZ_W'(FREEZE_TICKS - 1);
    localparam logic [FZ_W-1:0] FZ_HIT    = FZ_W'(FZ_HIT_MIN);

    slim_state_t       state_q, state_nxt;
    logic [9:0]        x_q, x_nxt;
    logic              dir_q, dir_nxt;
    logic [SW-1:0]     step_q, step_nxt;
    logic [AW-1:0]     anim_q, anim_nxt;
    logic [FZ_W-1:0]   fz_q, fz_nxt;
    logic              frozen_q, frozen_nxt;
    logic              alive_q, alive_nxt;
    logic [1:0]        anim_sel_q, fz_stage_q;
    logic [1:0]        anim_sel_nxt, fz_stage_nxt;
    logic              at_bound;

    // Sprite already touching the edge it is walking toward.
    assign at_bound = (!dir_q && (x_q == X_MIN_V)) || (dir_q && (x_q == X_MAX_V));

    always_comb begin
        state_nxt  = state_q;
        x_nxt      = x_q;
        dir_nxt    = dir_q;
        step_nxt   = step_q;
        anim_nxt   = anim_q;
        fz_nxt     = fz_q;
        frozen_nxt = frozen_q;
        alive_nxt  = alive_q;

        case (state_q)
            ST_WALK: begin
                // A hit pre-empts the step: patrol context is kept untouched
                // so the walk resumes exactly where it stopped after thawing.
                if (hit) begin
                    state_nxt  = ST_FROZEN;
                    fz_nxt     = '0;
                    frozen_nxt = 1'b1;
                end else if (tick) begin
                    anim_nxt = (anim_q == ANIM_LAST) ? '0 : anim_q + 1'b1;
                    // Turning costs a whole tick without moving.
                    if ((step_q == STEP_LAST) || at_bound) begin
                        dir_nxt  = ~dir_q;
                        step_nxt = '0;
                    end else begin
                        x_nxt    = dir_q ? (x_q + 10'd1) : (x_q - 10'd1);
                        step_nxt = step_q + 1'b1;
                    end
                end
            end
            ST_FROZEN: begin
                // Shatter is checked before the thaw tick so it wins a tie.
                if (hit && (fz_q >= FZ_HIT)) begin
                    state_nxt  = ST_DEAD;
                    alive_nxt  = 1'b0;
                    frozen_nxt = 1'b0;
                end else if (tick) begin
                    if (fz_q == FZ_LAST) begin
                        state_nxt  = ST_WALK;
                        frozen_nxt = 1'b0;
                        fz_nxt     = '0;
                    end else begin
                        fz_nxt = fz_q + 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                if (respawn) begin
                    state_nxt  = ST_WALK;
                    x_nxt      = X_INIT_V;
                    dir_nxt    = 1'b0;
                    step_nxt   = '0;
                    anim_nxt   = '0;
                    fz_nxt     = '0;
                    frozen_nxt = 1'b0;
                    alive_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_WALK;
            end
        endcase
    end

    // Frame selects are derived from the next counter values so they land
    // in the same cycle as the counters that drive them.
    slim_behavior_ctrl_frame_map #(
        .AW (AW)
    ) u_frame_map (
        .anim_cnt (anim_nxt),
        .fz_cnt   (fz_nxt),
        .anim_sel (anim_sel_nxt),
        .fz_stage (fz_stage_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WALK;
            x_q        <= X_INIT_V;
            dir_q      <= 1'b0;
            step_q     <= '0;
            anim_q     <= '0;
            fz_q       <= '0;
            frozen_q   <= 1'b0;
            alive_q    <= 1'b1;
            anim_sel_q <= 2'd0;
            fz_stage_q <= 2'd0;
        end else begin
            state_q    <= state_nxt;
            x_q        <= x_nxt;
            dir_q      <= dir_nxt;
            step_q     <= step_nxt;
            anim_q     <= anim_nxt;
            fz_q       <= fz_nxt;
            frozen_q   <= frozen_nxt;
            alive_q    <= alive_nxt;
            anim_sel_q <= anim_sel_nxt;
            fz_stage_q <= fz_stage_nxt;
        end
    end

    assign x_slim   = x_q;
    assign y_slim   = Y_INIT_V;
    assign dir      = dir_q;
    assign anim_sel = anim_sel_q;
    assign fz_stage = fz_stage_q;
    assign frozen   = frozen_q;
    assign alive    = alive_q;

endmodule

// File: tb/tb_slim_behavior_ctrl.sv
// Bench for slim_behavior_ctrl: two instances (default and X_INIT=2) share
// stimulus; each is compared every cycle against a behavioural model, plus
// directed spot checks of known positions.
module tb_slim_behavior_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0, tick = 1'b0, hit = 1'b0, respawn = 1'b0;

    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;
    logic       dir_a, dir_b, fr_a, fr_b, al_a, al_b;
    logic [1:0] as_a, as_b, fs_a, fs_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    slim_behavior_ctrl dut_a (
        .clk(clk), .rst(rst), .tick(tick), .hit(hit), .respawn(respawn),
        .x_slim(x_a), .y_slim(y_a), .dir(dir_a), .anim_sel(as_a),
        .fz_stage(fs_a), .frozen(fr_a), .alive(al_a)
    );

    slim_behavior_ctrl #(.X_INIT(2)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .hit(hit), .respawn(respawn),
        .x_slim(x_b), .y_slim(y_b), .dir(dir_b), .anim_sel(as_b),
        .fz_stage(fs_b), .frozen(fr_b), .alive(al_b)
    );

    // Behavioural model: mode 0=walking, 1=frozen, 2=dead.
    int xinit[2] = '{240, 2};
    int m_mode[2], m_x[2], m_dir[2], m_step[2], m_anim[2], m_fz[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_mode[i] = 0; m_x[i] = xinit[i]; m_dir[i] = 0;
        m_step[i] = 0; m_anim[i] = 0; m_fz[i] = 0;
    endtask

    task automatic model_step(input int i, input bit t, input bit h, input bit r, input bit rs);
        if (rs) begin
            model_reset(i);
        end else if (m_mode[i] == 0) begin
            if (h) begin
                m_mode[i] = 1;
                m_fz[i]   = 0;
            end else if (t) begin
                m_anim[i] = (m_anim[i] + 1) % 9;
                if (m_step[i] == 63 || (m_dir[i] == 0 && m_x[i] == 0) ||
                    (m_dir[i] == 1 && m_x[i] == 606)) begin
                    m_dir[i]  = 1 - m_dir[i];
                    m_step[i] = 0;
                end else begin
                    m_x[i]    = m_x[i] + (m_dir[i] == 1 ? 1 : -1);
                    m_step[i] = m_step[i] + 1;
                end
            end
        end else if (m_mode[i] == 1) begin
            if (h && m_fz[i] >= 2) begin
                m_mode[i] = 2;
            end else if (t) begin
                if (m_fz[i] == 126) begin
                    m_mode[i] = 0;
                    m_fz[i]   = 0;
                end else begin
                    m_fz[i] = m_fz[i] + 1;
                end
            end
        end else if (r) begin
            model_reset(i);
        end
    endtask

    function automatic int bucket(input int v, input int lo, input int hi);
        if (v >= hi) return 2;
        if (v >= lo) return 1;
        return 0;
    endfunction

    task automatic check_model();
        check("a.x",      32'(x_a),   32'(m_x[0]));
        check("a.y",      32'(y_a),   32'd192);
        check("a.dir",    32'(dir_a), 32'(m_dir[0]));
        check("a.anim",   32'(as_a),  32'(bucket(m_anim[0], 2, 6)));
        check("a.fz",     32'(fs_a),  32'(bucket(m_fz[0], 2, 8)));
        check("a.frozen", 32'(fr_a),  32'(m_mode[0] == 1));
        check("a.alive",  32'(al_a),  32'(m_mode[0] != 2));
        check("b.x",      32'(x_b),   32'(m_x[1]));
        check("b.y",      32'(y_b),   32'd192);
        check("b.dir",    32'(dir_b), 32'(m_dir[1]));
        check("b.anim",   32'(as_b),  32'(bucket(m_anim[1], 2, 6)));
        check("b.fz",     32'(fs_b),  32'(bucket(m_fz[1], 2, 8)));
        check("b.frozen", 32'(fr_b),  32'(m_mode[1] == 1));
        check("b.alive",  32'(al_b),  32'(m_mode[1] != 2));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1ns later.
    task automatic cyc(input bit t, input bit h, input bit r, input bit rs);
        rst = rs; tick = t; hit = h; respawn = r;
        @(posedge clk);
        model_step(0, t, h, r, rs);
        model_step(1, t, h, r, rs);
        #1;
        rst = 1'b0; tick = 1'b0; hit = 1'b0; respawn = 1'b0;
        check_model();
    endtask

    initial begin
        int hdiv;

        // Reset values and the first patrol steps of both instances.
        cyc(0, 0, 0, 1);
        check("rst.x",      32'(x_a),  32'd240);
        check("rst.alive",  32'(al_a), 32'd1);
        check("rst.frozen", 32'(fr_a), 32'd0);
        check("rst.xb",     32'(x_b),  32'd2);
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 0, 0, 0);
            if (k == 3) begin
                check("minb.x",   32'(x_b),   32'd0);
                check("minb.dir", 32'(dir_b), 32'd1);
            end
            if (k == 4) check("minb.back", 32'(x_b), 32'd1);
        end
        check("t10.x",    32'(x_a),   32'd230);
        check("t10.dir",  32'(dir_a), 32'd0);
        check("t10.anim", 32'(as_a),  32'd0);

        // Full patrol leg then turn.
        cyc(0, 0, 0, 1);
        for (int k = 1; k <= 64; k++) cyc(1, 0, 0, 0);
        check("leg.x",   32'(x_a),   32'd177);
        check("leg.dir", 32'(dir_a), 32'd1);
        cyc(1, 0, 0, 0);
        check("leg.next", 32'(x_a), 32'd178);

        // Freeze and thaw.
        cyc(0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("fz.frozen", 32'(fr_a), 32'd1);
        check("fz.x",      32'(x_a),  32'd235);
        for (int k = 1; k <= 126; k++) cyc(1, 0, 0, 0);
        check("fz.still", 32'(fr_a), 32'd1);
        cyc(1, 0, 0, 0);
        check("thaw.frozen", 32'(fr_a), 32'd0);
        cyc(1, 0, 0, 0);
        check("thaw.x", 32'(x_a), 32'd234);

        // Debounced second hit, then shatter, dead inertness, respawn.
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("deb.frozen", 32'(fr_a), 32'd1);
        check("deb.alive",  32'(al_a), 32'd1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("shat.alive",  32'(al_a), 32'd0);
        check("shat.frozen", 32'(fr_a), 32'd0);
        cyc(1, 1, 0, 0);
        check("dead.alive", 32'(al_a), 32'd0);
        check("dead.x",     32'(x_a),  32'd240);
        cyc(0, 1, 1, 0);
        check("resp.alive", 32'(al_a), 32'd1);
        check("resp.x",     32'(x_a),  32'd240);

        // Reset in the middle of a freeze.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int k = 1; k <= 3; k++) cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 1);
        check("rstfz.frozen", 32'(fr_a), 32'd0);
        check("rstfz.fz",     32'(fs_a), 32'd0);
        check("rstfz.x",      32'(x_a),  32'd240);

        // Randomised traffic; alternating hit density so thaws and shatters both occur.
        for (int k = 0; k < 3000; k++) begin
            hdiv = (((k / 1000) % 2) == 0) ? 400 : 25;
            cyc(bit'($urandom_range(0, 1)),
                $urandom_range(0, hdiv - 1) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 799) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
